test_harness: RTL and testbench

// - I2C slave endpoint of the PWM-generator system: 7-bit-addressed device holding a bank of 32-bit control registers.
// - Registers are written and read over I2C as 4-byte, MSB-first transfers selected by an 8-bit register address.
// - The register bank is exported flat for the downstream PWM logic.
// - No clock stretching; the bus master is an external I2C controller.

---
 rtl/test_harness_pkg.sv | 24 ++
 rtl/test_harness_i2c_line_filter.sv | 46 ++++
 rtl/test_harness.sv | 170 +++++++++++++++++
 tb/tb_test_harness.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_harness_pkg.sv
// Shared definitions for the I2C register endpoint: FSM states, default
// device parameters and bus ACK/NAK levels.
package test_harness_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ACK_ADDR,
    REGADDR,
    ACK_REG,
    WDATA,
    ACK_W,
    RDATA,
    RACK
  } state_t;

  localparam logic [6:0]  DEV_ADDR_DEFAULT = 7'h3C;
  localparam int unsigned NUM_REGS_DEFAULT = 4;

  // SDA levels as seen on the wire during the acknowledge clock
  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

endpackage

// File: rtl/test_harness_i2c_line_filter.sv
// Synchronizes an asynchronous I2C line, rejects pulses shorter than DEB_LEN
// clocks and flags the accepted rising/falling transitions for one cycle.
module i2c_line_filter #(
  parameter int unsigned DEB_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned    CW      = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_LEN - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A new level is accepted only after DEB_LEN consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b11;
      cnt   <= '0;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/test_harness.sv
// I2C slave endpoint exposing a bank of 32-bit registers, written and read
// as 4-byte MSB-first words behind an 8-bit register pointer.
module test_harness
  import test_harness_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
  parameter int unsigned DEB_LEN  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scl_in,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic [32*NUM_REGS-1:0] regs
);

  localparam int unsigned IW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]  REG_LIMIT = 9'(NUM_REGS);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start, stop, byte_done;

  state_t state, state_nxt;

  logic [3:0]  bit_cnt;
  logic [1:0]  byte_cnt;
  logic [7:0]  sh;
  logic [7:0]  reg_ptr;
  logic [7:0]  ptr_inc;
  logic        rw;
  logic        mack;
  logic [23:0] wbuf;
  logic [31:0] shadow;
  logic [31:0] bank [NUM_REGS];
  logic        cur_hit, nxt_hit;
  logic [31:0] cur_word, nxt_word;

  i2c_line_filter #(.DEB_LEN(DEB_LEN)) u_scl_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (scl_in),
    .level   (scl),
    .rise    (scl_rise),
    .fall    (scl_fall)
  );

  i2c_line_filter #(.DEB_LEN(DEB_LEN)) u_sda_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (sda_in),
    .level   (sda),
    .rise    (sda_rise),
    .fall    (sda_fall)
  );

  assign start     = sda_fall & scl;
  assign stop      = sda_rise & scl;
  assign byte_done = scl_fall && (bit_cnt == 4'd8);

  always_comb begin
    ptr_inc  = reg_ptr + 8'd1;
    cur_hit  = {1'b0, reg_ptr} < REG_LIMIT;
    nxt_hit  = {1'b0, ptr_inc} < REG_LIMIT;
    cur_word = cur_hit ? bank[reg_ptr[IW-1:0]] : '0;
    nxt_word = nxt_hit ? bank[ptr_inc[IW-1:0]] : '0;
  end

  always_comb begin
    regs = '0;
    for (int unsigned n = 0; n < NUM_REGS; n++) regs[32*n +: 32] = bank[n];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ADDR;
    end else if (stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        ADDR:     if (byte_done) state_nxt = (sh[7:1] == DEV_ADDR) ? ACK_ADDR : IDLE;
        ACK_ADDR: if (scl_fall)  state_nxt = rw ? RDATA : REGADDR;
        REGADDR:  if (byte_done) state_nxt = ACK_REG;
        ACK_REG:  if (scl_fall)  state_nxt = WDATA;
        WDATA:    if (byte_done) state_nxt = ACK_W;
        ACK_W:    if (scl_fall)  state_nxt = WDATA;
        RDATA:    if (scl_fall && bit_cnt == 4'd7) state_nxt = RACK;
        RACK:     if (scl_fall)  state_nxt = (mack == I2C_NAK) ? IDLE : RDATA;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    sda_oe = 1'b0;
    unique case (state)
      ACK_ADDR, ACK_REG, ACK_W: sda_oe = ~I2C_ACK;
      RDATA:                    sda_oe = ~shadow[31];
      default:                  sda_oe = 1'b0;
    endcase
  end

  // START/STOP outrank any bit activity seen in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sh       <= '0;
      reg_ptr  <= '0;
      rw       <= 1'b0;
      mack     <= I2C_NAK;
      wbuf     <= '0;
      shadow   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (start || stop) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
    end else begin
      unique case (state)
        ADDR, REGADDR, WDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            sh      <= {sh[6:0], sda};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (byte_done) begin
            bit_cnt <= '0;
            if (state == ADDR) begin
              rw <= sh[0];
              if (sh[0]) shadow <= cur_word;
            end else if (state == REGADDR) begin
              reg_ptr <= sh;
            end else begin
              wbuf     <= {wbuf[15:0], sh};
              byte_cnt <= byte_cnt + 2'd1;
              if (byte_cnt == 2'd3) begin
                if (cur_hit) bank[reg_ptr[IW-1:0]] <= {wbuf, sh};
                reg_ptr <= ptr_inc;
              end
            end
          end
        end
        RDATA: begin
          if (scl_fall) begin
            shadow  <= {shadow[30:0], 1'b0};
            bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
          end
        end
        RACK: begin
          if (scl_rise) begin
            mack <= sda;
          end else if (scl_fall && mack == I2C_ACK) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              reg_ptr <= ptr_inc;
              shadow  <= nxt_word;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_harness.sv
// Bench for the I2C register endpoint: a bit-level bus master drives directed
// and random transfers, checked against a word-level register model.
module tb_test_harness;

  localparam int Q = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         scl_m;
  logic         sda_m;
  logic         sda_oe;
  logic [127:0] regs;
  logic         sda_line;

  int checks = 0;
  int errors = 0;
  int oe_viol = 0;
  logic scl_p = 1'b1;
  logic oe_p  = 1'b0;

  logic [31:0]  mreg [4];
  bit           glitch = 0;
  byte unsigned wq[$];
  byte unsigned rq[$];

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_oe;

  test_harness #(.DEV_ADDR(7'h3C), .NUM_REGS(4), .DEB_LEN(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .scl_in (scl_m),
    .sda_in (sda_line),
    .sda_oe (sda_oe),
    .regs   (regs)
  );

  // The slave may only move SDA while SCL is low
  always @(negedge clk) begin
    if (!rst && scl_m && scl_p && sda_oe !== oe_p) oe_viol++;
    scl_p = scl_m;
    oe_p  = sda_oe;
  end

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1; hold(Q);
    scl_m = 1'b1; hold(Q);
    sda_m = 1'b0; hold(Q);
    scl_m = 1'b0; hold(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0; hold(Q);
    scl_m = 1'b1; hold(Q);
    sda_m = 1'b1; hold(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      if (glitch) begin
        hold(2); scl_m = 1'b1; hold(2); scl_m = 1'b0; hold(Q - 4);
      end else begin
        hold(Q);
      end
      scl_m = 1'b1;
      hold(4);
      if (glitch && b[i]) begin
        sda_m = 1'b0; hold(2); sda_m = 1'b1; hold(2*Q - 8);
      end else begin
        hold(2*Q - 4);
      end
      scl_m = 1'b0; hold(Q);
    end
    sda_m = 1'b1; hold(Q);
    scl_m = 1'b1; hold(Q);
    ack = sda_line;
    hold(Q);
    scl_m = 1'b0; hold(Q);
  endtask

  task automatic read_byte(input logic nak, output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; hold(Q);
      scl_m = 1'b1; hold(Q);
      b[i] = sda_line;
      hold(Q);
      scl_m = 1'b0; hold(Q);
    end
    sda_m = nak; hold(Q);
    scl_m = 1'b1; hold(2*Q);
    scl_m = 1'b0; hold(Q);
    sda_m = 1'b1;
  endtask

  task automatic do_write(input logic [7:0] dev, input logic [7:0] ra, output int acks);
    logic a;
    acks = 0;
    i2c_start;
    write_byte(dev, a); if (a == 1'b0) acks++;
    write_byte(ra, a);  if (a == 1'b0) acks++;
    foreach (wq[k]) begin
      write_byte(wq[k], a);
      if (a == 1'b0) acks++;
    end
    i2c_stop;
  endtask

  task automatic do_read(input logic [7:0] ra, input int n, input bit rstart, output int acks);
    logic a;
    logic [7:0] b;
    acks = 0;
    rq.delete();
    i2c_start;
    write_byte(8'h78, a); if (a == 1'b0) acks++;
    write_byte(ra, a);    if (a == 1'b0) acks++;
    if (!rstart) i2c_stop;
    i2c_start;
    write_byte(8'h79, a); if (a == 1'b0) acks++;
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      rq.push_back(b);
    end
    i2c_stop;
  endtask

  // Word-level model: each complete group of four bytes lands at the pointer
  function automatic void model_write(input int ra);
    int p = ra;
    for (int k = 0; k + 3 < wq.size(); k += 4) begin
      if (p < 4) mreg[p] = {wq[k], wq[k+1], wq[k+2], wq[k+3]};
      p++;
    end
  endfunction

  task automatic check_read(input string tag, input int ra);
    int p = ra;
    logic [31:0] w;
    for (int k = 0; k < rq.size(); k++) begin
      w = (p < 4) ? mreg[p] : 32'h0;
      check($sformatf("%s_b%0d", tag, k), rq[k], w[31 - 8*(k%4) -: 8]);
      if (k % 4 == 3) p++;
    end
  endtask

  task automatic check_regs(input string tag);
    for (int r = 0; r < 4; r++)
      check($sformatf("%s_reg%0d", tag, r), regs[32*r +: 32], mreg[r]);
  endtask

  initial begin
    int   acks;
    int   ra;
    int   n;
    bit   rs;
    logic a;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    for (int r = 0; r < 4; r++) mreg[r] = 32'h0;
    hold(5);
    check("rst_oe", sda_oe, 1'b0);
    check("rst_regs", regs, 128'h0);
    rst = 1'b0;
    hold(10);

    wq = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_write(8'h78, 8'h00, acks); model_write(0);
    check("w0_acks", acks, 6);
    check("w0_reg0", regs[31:0], 32'h12345678);

    do_read(8'h00, 4, 1'b0, acks);
    check("r0_acks", acks, 3);
    check("r0_word", {rq[0], rq[1], rq[2], rq[3]}, 32'h12345678);

    do_read(8'h00, 4, 1'b1, acks);
    check("r0rs_acks", acks, 3);
    check("r0rs_word", {rq[0], rq[1], rq[2], rq[3]}, 32'h12345678);

    wq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    do_write(8'hA0, 8'h00, acks);
    check("wrong_acks", acks, 0);
    check_regs("wrong");

    wq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    do_write(8'h78, 8'h01, acks); model_write(1);
    check("w1_acks", acks, 6);
    check("w1_reg1", regs[63:32], 32'hAABBCCDD);

    wq = '{8'h11, 8'h22};
    do_write(8'h78, 8'h01, acks); model_write(1);
    check("part_acks", acks, 4);
    check("part_reg1", regs[63:32], 32'hAABBCCDD);

    wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    do_write(8'h78, 8'h02, acks); model_write(2);
    check("burst_acks", acks, 10);
    check("burst_reg2", regs[95:64], 32'h01020304);
    check("burst_reg3", regs[127:96], 32'h05060708);

    do_read(8'h07, 4, 1'b0, acks);
    check("r7_acks", acks, 3);
    check("r7_word", {rq[0], rq[1], rq[2], rq[3]}, 32'h0);

    glitch = 1;
    do_read(8'h02, 8, 1'b1, acks);
    glitch = 0;
    check("r2_acks", acks, 3);
    check("r2_len", rq.size(), 8);
    check_read("r2", 2);

    for (int it = 0; it < 6; it++) begin
      ra = $urandom_range(0, 5);
      n  = $urandom_range(1, 8);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
      glitch = ($urandom_range(0, 1) == 1);
      do_write(8'h78, 8'(ra), acks); model_write(ra);
      check($sformatf("rw%0d_acks", it), acks, n + 2);
      check_regs($sformatf("rw%0d", it));
      ra = $urandom_range(0, 7);
      n  = ($urandom_range(0, 1) == 1) ? 8 : 4;
      rs = ($urandom_range(0, 1) == 1);
      do_read(8'(ra), n, rs, acks);
      glitch = 0;
      check($sformatf("rr%0d_acks", it), acks, 3);
      check($sformatf("rr%0d_len", it), rq.size(), n);
      check_read($sformatf("rr%0d", it), ra);
    end

    wq = '{8'h12, 8'h34, 8'h56, 8'h78};
    do_write(8'h78, 8'h00, acks); model_write(0);
    i2c_start;
    write_byte(8'h78, a);
    write_byte(8'h00, a);
    i2c_stop;
    i2c_start;
    write_byte(8'h79, a);
    hold(2);
    check("pre_rst_oe", sda_oe, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_oe", sda_oe, 1'b0);
    hold(3);
    check("rst_mid_regs", regs, 128'h0);
    rst = 1'b0;
    i2c_stop;
    hold(10);
    check("oe_timing", oe_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
